// File: rtl/letc_pkg.sv
// Shared SRAM types and constants for the LETC memory arbiter.
// Build option LETC_SRAM_ARB_RR_EN is consumed by letc_sram_arbiter.
package letc_pkg;

   localparam int unsigned LETC_SRAM_DEPTH       = 1024;
   localparam int unsigned LETC_SRAM_DATA_WIDTH  = 32;
   localparam int unsigned LETC_SRAM_ADDR_WIDTH  = $clog2(LETC_SRAM_DEPTH);
   localparam int unsigned LETC_SRAM_ARB_MAX_REQ = 8;

   typedef struct packed {
      logic                              we;
      logic [LETC_SRAM_ADDR_WIDTH-1:0]   addr;
      logic [LETC_SRAM_DATA_WIDTH-1:0]   wdata;
      logic [LETC_SRAM_DATA_WIDTH/8-1:0] wmask;
   } sram_req_t;

   // Index of the set bit in a one-hot vector; 0 when no bit is set.
   function automatic int unsigned letc_onehot_idx(input logic [LETC_SRAM_ARB_MAX_REQ-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned k = 0; k < LETC_SRAM_ARB_MAX_REQ; k++) begin
         if (oh[k]) idx = k;
      end
      return idx;
   endfunction

endpackage

// File: rtl/letc_rr_picker.sv
// Combinational rotating-priority picker: first valid requester at or after
// i_ptr (modulo NUM_REQ) wins. Pointer tied to 0 gives fixed priority.
module letc_rr_picker
   import letc_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [PW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_grant
);

   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      found   = 1'b0;
      idx     = '0;
      o_grant = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = PW'((32'(i_ptr) + k) % NUM_REQ);
         if (!found && i_valid[idx]) begin
            o_grant[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/letc_sram_arbiter.sv
// Single-port SRAM arbiter for NUM_REQ clients with a one-cycle response path.
// Define LETC_SRAM_ARB_RR_EN for round-robin priority; default is fixed priority.
module letc_sram_arbiter
   import letc_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DEPTH      = LETC_SRAM_DEPTH,
   parameter int unsigned DATA_WIDTH = LETC_SRAM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_REQ-1:0]                      req_valid,
   output logic [NUM_REQ-1:0]                      req_ready,
   input  logic [NUM_REQ-1:0]                      req_we,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]      req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_wdata,
   input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]    req_wmask,
   output logic [NUM_REQ-1:0]                      rsp_valid,
   output logic [DATA_WIDTH-1:0]                   rsp_rdata,
   output logic                                    sram_we,
   output logic [ADDR_WIDTH-1:0]                   sram_addr,
   output logic [DATA_WIDTH-1:0]                   sram_wdata,
   output logic [DATA_WIDTH/8-1:0]                 sram_wmask,
   input  logic [DATA_WIDTH-1:0]                   sram_rdata
);

   localparam int unsigned PW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] w_pick;
   logic [NUM_REQ-1:0] w_gnt;
   logic [PW-1:0]      w_ptr;
   logic [NUM_REQ-1:0] r_rsp_sel;
   logic               r_rsp_is_rd;

   letc_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_picker (
      .i_valid (req_valid),
      .i_ptr   (w_ptr),
      .o_grant (w_pick)
   );

   assign w_gnt     = rst ? '0 : w_pick;
   assign req_ready = w_gnt;

`ifdef LETC_SRAM_ARB_RR_EN
   logic [PW-1:0]                    r_rr_ptr;
   logic [LETC_SRAM_ARB_MAX_REQ-1:0] w_gnt_ext;
   int unsigned                      w_gnt_idx;

   always_comb begin
      w_gnt_ext              = '0;
      w_gnt_ext[NUM_REQ-1:0] = w_gnt;
   end

   assign w_gnt_idx = letc_onehot_idx(w_gnt_ext);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (|w_gnt) begin
         r_rr_ptr <= PW'((w_gnt_idx + 1) % NUM_REQ);
      end
   end

   assign w_ptr = r_rr_ptr;
`else
   assign w_ptr = '0;
`endif

   always_comb begin
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wmask = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (w_gnt[k]) begin
            sram_we    = req_we[k];
            sram_addr  = req_addr[k];
            sram_wdata = req_wdata[k];
            sram_wmask = req_wmask[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_sel   <= '0;
         r_rsp_is_rd <= 1'b0;
      end else begin
         r_rsp_sel   <= w_gnt;
         r_rsp_is_rd <= |(w_gnt & ~req_we);
      end
   end

   // Gating with rst drops a response whose request was accepted just before reset.
   assign rsp_valid = rst ? '0 : r_rsp_sel;
   assign rsp_rdata = (r_rsp_is_rd && !rst) ? sram_rdata : '0;

endmodule

// File: doc/letc_sram_arbiter.md
# letc_sram_arbiter

Shares one port of the `intel_fpga_sram` block between `NUM_REQ` requesters, such as the instruction fetch, load/store and debug paths. Each requester has its own valid/ready request channel and a response strobe. The arbiter grants one request per cycle, drives the SRAM port directly, and returns read data or a write acknowledgement one cycle later. It sits between the LETC core-side memory clients and the on-chip SRAM in the FPGA wrapper.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DEPTH`, 1024: SRAM words; must be a power of two.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: word address width; derived, do not override.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  `[NUM_REQ]`  request present, per requester.
- `req_ready`  out  `[NUM_REQ]`  grant; one-hot or zero.
- `req_we`  in  `[NUM_REQ]`  1 = write, 0 = read.
- `req_addr`  in  `[NUM_REQ][ADDR_WIDTH]`  word address.
- `req_wdata`  in  `[NUM_REQ][DATA_WIDTH]`  write data.
- `req_wmask`  in  `[NUM_REQ][DATA_WIDTH/8]`  byte enables; 1 = write that byte.
- `rsp_valid`  out  `[NUM_REQ]`  response strobe; one-hot or zero.
- `rsp_rdata`  out  `DATA_WIDTH`  read data; shared by all requesters and qualified by `rsp_valid`.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  `ADDR_WIDTH`  SRAM address.
- `sram_wdata`  out  `DATA_WIDTH`  SRAM write data.
- `sram_wmask`  out  `DATA_WIDTH/8`  SRAM byte mask.
- `sram_rdata`  in  `DATA_WIDTH`  SRAM registered read data, 1-cycle latency.

## Operation
- A handshake occurs in cycle N when `req_valid[i] && req_ready[i]`.
- `req_ready` is combinational from `req_valid` and the priority state. It never asserts for a requester whose `req_valid` is low.
- The granted requester's `we`, `addr`, `wdata` and `wmask` are muxed combinationally onto the `sram_*` outputs in cycle N.
- With no grant: `sram_we`=0, `sram_wmask`=0, `sram_addr`=0, `sram_wdata`=0.
- A requester must hold its request fields stable while `req_valid` is high and `req_ready` is low.
- Response registers:
  - `rsp_sel` is the one-hot grant, registered.
  - `rsp_is_rd` records whether the granted request was a read.
- In cycle N+1, `rsp_valid` = `rsp_sel`.
- `rsp_rdata` = `sram_rdata` when `rsp_is_rd` is set; otherwise 0, which serves as the write acknowledgement.
- Responses cannot be back-pressured. Requesters must always accept them.
- Priority, with `LETC_SRAM_ARB_RR_EN` defined: round-robin.
  - Register `rr_ptr` holds the highest-priority index.
  - The search for a valid requester runs `rr_ptr`, `rr_ptr`+1, … modulo `NUM_REQ`.
  - After a handshake by requester i, `rr_ptr` becomes (i+1) mod `NUM_REQ`.
  - With no handshake, `rr_ptr` holds.
- Back-to-back requests are allowed. A request may be accepted in cycle N+1 while the response for cycle N is being delivered, giving a throughput of 1 request per cycle.
- Write then read of the same address in consecutive cycles returns the new data; the SRAM handles read-after-write. No forwarding is needed in the arbiter.
- Reset:
  - While `rst` is high, `req_ready` is all 0 and no SRAM access occurs.
  - On the first edge with `rst` high: `rsp_valid` is 0, `rsp_rdata` is 0, `rr_ptr` is 0 and `rsp_is_rd` is 0.
  - A request accepted in the cycle before reset asserts produces no response.

## Timing
- Request to grant: 0 cycles (combinational).
- Grant to response: exactly 1 cycle.
- Maximum one outstanding transaction in flight.
- The combinational path `req_valid` -> `req_ready` is a known critical path. `NUM_REQ` ≤ 8 keeps it shallow.

## Configuration
- `LETC_SRAM_ARB_RR_EN` defined: round-robin priority as described above, with the `rr_ptr` register present.
- `LETC_SRAM_ARB_RR_EN` undefined: fixed priority, lowest index wins. `rr_ptr` is not synthesised.
- All other behaviour is identical in both builds.

## Structure
- `letc_pkg` holds:
  - `sram_req_t`: a struct of `we`, `addr`, `wdata` and `wmask`, sized from package constants `LETC_SRAM_DEPTH` = 1024 and `LETC_SRAM_DATA_WIDTH` = 32.
  - `LETC_SRAM_ARB_MAX_REQ` = 8.
- One sub-module, `letc_rr_picker`: it takes the `valid` vector and the pointer and returns a one-hot grant.
  - Parameterised on `NUM_REQ`.
  - Purely combinational; reused for fixed priority with the pointer tied to 0.

## Test plan
- Single read: after reset, preload addr 0x010 = 0xDEADBEEF via requester 0. Requester 2 then reads 0x010. Expect `req_ready[2]` in the same cycle, `rsp_valid`=4'b0100 one cycle later, and `rsp_rdata`=0xDEADBEEF.
- Byte mask: write 0xAABBCCDD, then write 0x11223344 with mask 4'b0101, then read. Expect 0xAA22CC44.
- Round-robin (RR_EN): all four requesters hold `req_valid` for 8 cycles. Expect grants in the order 0,1,2,3,0,1,2,3 and no two-hot `req_ready`.
- Fixed priority (RR_EN undefined): requesters 1 and 3 hold valid. Expect requester 1 granted every cycle and requester 3 never granted while 1 is valid.
- Back-to-back: requester 0 writes 0x5 = 0x12345678 in cycle N and requester 1 reads 0x5 in cycle N+1. Expect a write ack in N+1 with `rsp_rdata`=0, then `rsp_valid[1]` in N+2 with 0x12345678.
- Reset mid-operation: accept a read in cycle N and assert `rst` in N+1. Expect `rsp_valid`=0 in N+1 onward, `req_ready`=0 while `rst` is high, and `rr_ptr` back to 0.
